// File: rtl/fet_gate_test_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fet_gate_test_sequencer
// Description : Bring-up sequencer for a discrete-FET logic gate board.
//               Drives all four {A,B} vectors, waits a settle time, samples
//               the synchronised gate output, and checks it against the
//               selected truth table over a programmable number of loops.
// Ports       : clk, rst_n        - clock, async active-low reset
//               start, abort      - run request / synchronous abort
//               func_sel, loops   - expected function and pass count
//               dut_a, dut_b      - gate inputs driven to the board
//               dut_y             - gate output from board (async)
//               busy, done, pass  - run status
//               err_count         - saturating mismatch count
//               fail_vec          - sticky per-vector fail flags
// Revision    : 1.0 - initial release
// ============================================================================
module fet_gate_test_sequencer #(
   parameter int SETTLE_CYCLES = 16,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [2:0]       func_sel,
   input  logic [7:0]       loops,
   output logic             dut_a,
   output logic             dut_b,
   input  logic             dut_y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [3:0]       fail_vec
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_APPLY  = 3'd1,
      S_SETTLE = 3'd2,
      S_SAMPLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [7:0]       c_settle_load = 8'(SETTLE_CYCLES - 1);
   localparam logic [ERR_W-1:0] c_err_max     = '1;

   state_t     r_state;
   logic       r_y_meta;
   logic       r_y_s;
   logic [2:0] r_func;
   logic [7:0] r_loops;
   logic [7:0] r_loop_cnt;
   logic [1:0] r_idx;
   logic [7:0] r_settle;
   logic       w_expected;

   // Board output is asynchronous to clk; nothing downstream sees it raw.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y_meta <= 1'b0;
         r_y_s    <= 1'b0;
      end else begin
         r_y_meta <= dut_y;
         r_y_s    <= r_y_meta;
      end
   end

   // Expected output uses the registered pins, which equal r_idx in SAMPLE.
   always_comb begin
      w_expected = 1'b0;
      case (r_func)
         3'd0: w_expected = dut_a;
         3'd1: w_expected = ~dut_a;
         3'd2: w_expected = dut_a & dut_b;
         3'd3: w_expected = ~(dut_a & dut_b);
         3'd4: w_expected = dut_a | dut_b;
         3'd5: w_expected = ~(dut_a | dut_b);
         3'd6: w_expected = dut_a ^ dut_b;
         default: w_expected = ~(dut_a ^ dut_b);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_func     <= 3'd0;
         r_loops    <= 8'd1;
         r_loop_cnt <= 8'd0;
         r_idx      <= 2'd0;
         r_settle   <= 8'd0;
         dut_a      <= 1'b0;
         dut_b      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_vec   <= 4'd0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            // Abort in IDLE also swallows a coincident start.
            if (r_state != S_IDLE) begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
               dut_a   <= 1'b0;
               dut_b   <= 1'b0;
               pass    <= 1'b0;
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_func     <= func_sel;
                     r_loops    <= (loops == 8'd0) ? 8'd1 : loops;
                     r_loop_cnt <= 8'd0;
                     r_idx      <= 2'd0;
                     err_count  <= '0;
                     fail_vec   <= 4'd0;
                     pass       <= 1'b0;
                     busy       <= 1'b1;
                     r_state    <= S_APPLY;
                  end
               end
               S_APPLY: begin
                  dut_a    <= r_idx[1];
                  dut_b    <= r_idx[0];
                  r_settle <= c_settle_load;
                  r_state  <= S_SETTLE;
               end
               S_SETTLE: begin
                  if (r_settle == 8'd0) begin
                     r_state <= S_SAMPLE;
                  end else begin
                     r_settle <= r_settle - 8'd1;
                  end
               end
               S_SAMPLE: begin
                  if (r_y_s != w_expected) begin
                     if (err_count != c_err_max) begin
                        err_count <= err_count + 1'b1;
                     end
                     fail_vec[r_idx] <= 1'b1;
                  end
                  if (r_idx == 2'd3) begin
                     if (r_loop_cnt == 8'(r_loops - 8'd1)) begin
                        r_state <= S_DONE;
                     end else begin
                        r_idx      <= 2'd0;
                        r_loop_cnt <= r_loop_cnt + 8'd1;
                        r_state    <= S_APPLY;
                     end
                  end else begin
                     r_idx   <= r_idx + 2'd1;
                     r_state <= S_APPLY;
                  end
               end
               S_DONE: begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  pass    <= (err_count == '0);
                  dut_a   <= 1'b0;
                  dut_b   <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/fet_gate_test_sequencer.md
Name: fet_gate_test_sequencer

Overview:
Bring-up sequencer for a single discrete-FET logic gate board (NOT/BUF/NAND/AND/OR/NOR/XOR/XNOR built from PFET/NFET pairs). It applies all four A/B input combinations to the board and waits a settle time for the slow discrete output. It then samples the gate output through a synchroniser and compares it against the selected gate's truth table. Errors are accumulated over a programmable number of loops. It sits in the FPGA test harness between the host control registers and the board I/O pins.

Parameters:
SETTLE_CYCLES, 16, clk cycles between driving a vector and sampling Y; legal range 2..255 (covers the 2-flop synchroniser).
ERR_W, 8, width of the saturating error counter.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a run; ignored while busy
abort  in  1  synchronous abort; wins over every other event
func_sel  in  3  expected function: 0 BUF(Y=A), 1 NOT(Y=~A), 2 AND, 3 NAND, 4 OR, 5 NOR, 6 XOR, 7 XNOR
loops  in  8  number of full 4-vector passes; 0 is treated as 1
dut_a  out  1  gate input A to board
dut_b  out  1  gate input B to board
dut_y  in  1  gate output from board, asynchronous to clk
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  one-cycle pulse at the end of a completed run
pass  out  1  err_count==0 at the end of the last run; held
err_count  out  ERR_W  mismatches in the last run, saturating at all-ones; held
fail_vec  out  4  sticky per-vector fail flags, bit i = vector {A,B}=i

Behaviour:
- Reset (async, rst_n=0): state IDLE. dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0. Synchroniser flops reset to 0.
- dut_y passes through a 2-flop synchroniser (y_s) before any use.
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE: start=1 latches func_sel and loops (0→1). It clears err_count, fail_vec, pass, sets vector idx=0 and loop counter=0, then goes to APPLY. busy=1 from the next cycle.
- APPLY (1 cycle): registers dut_a=idx[1], dut_b=idx[0]. Loads the settle counter with SETTLE_CYCLES-1, then goes to SETTLE.
- SETTLE: decrements the counter each cycle. When the counter is 0, goes to SAMPLE, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle): expected = f(func_sel, dut_a, dut_b). On y_s != expected: err_count += 1 (saturating, no wrap) and fail_vec[idx] set.
  - If idx==3 and loop counter == loops-1 → DONE.
  - Else if idx==3: idx=0, loop counter increments, → APPLY.
  - Else: idx increments, → APPLY.
- Each vector takes SETTLE_CYCLES+2 cycles. If start is accepted at edge k, done is high during the cycle following edge k+1+4·L·(SETTLE_CYCLES+2), where L is the effective loop count.
- DONE (1 cycle): done=1, busy=0, pass=(err_count==0), dut_a=dut_b=0, then → IDLE. Results hold until the next accepted start.
- abort=1 in any non-IDLE state: next state IDLE, busy=0, dut_a=dut_b=0, done not pulsed, pass=0. err_count and fail_vec keep partial values.
- abort and start in the same cycle in IDLE: abort wins, no run starts.
- start while busy: ignored, with no effect on the latched configuration.
- func_sel and loops changing mid-run: no effect, because both are latched at start.
- For BUF and NOT, the B input is still swept and ignored by the expected function.
- Reset asserted mid-run: immediate return to reset values, with dut_a and dut_b driven 0 asynchronously.

Test Plan:
- NAND selected, ideal NAND board model with 3-cycle output delay, SETTLE_CYCLES=16, loops=1 → done at start+73 cycles, pass=1, err_count=0, fail_vec=0000; dut_a/dut_b sequence 00,01,10,11.
- AND selected, dut_y stuck at 1, loops=1 → err_count=3, fail_vec=0111, pass=0.
- XOR selected, model outputs 1 for vector 11, loops=3 → err_count=3, fail_vec=1000; loops=0 → err_count=1 (treated as one pass).
- NOT selected, correct inverter with 20-cycle output delay and SETTLE_CYCLES=16 → each vector samples the previous vector's value: vector 10 mismatches on every run and vector 00 mismatches on the first run after reset. Result is err_count≥1, pass=0; with SETTLE_CYCLES=24 the result is pass=1.
- NOR selected, dut_y stuck at 1, loops=100 → err_count saturates at 255 (ERR_W=8), fail_vec=1110.
- Abort at cycle 30 of a run → busy drops the next cycle, no done pulse, dut_a=dut_b=0. A second start 1 cycle later runs normally. A separate case drops rst_n mid-SETTLE → all outputs return to reset values immediately.
